mod_counter_rr_scheduler: RTL

- Shares one external 8-bit MOD counter between NUM_REQ requesters, each asking for a timed interval: MOD value, preload value and number of rollovers.
- Picks requesters round-robin, then sequences the counter through load, start, wait-for-rollovers and stop.
- Returns a one-cycle done pulse to the winner.
- Sits between timer clients and the MOD counter; it is the only driver of the counter's command inputs.

---
 rtl/mod_counter_sched_pkg.sv | 18 +
 rtl/rr_priority_picker.sv | 38 +++
 rtl/mod_counter_rr_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mod_counter_sched_pkg.sv
// Shared types and constants for the MOD counter round-robin scheduler.
// Counter width and rollover-count width defaults live here so client code can match them.
package mod_counter_sched_pkg;

  localparam int CNT_W_DEFAULT = 8;
  localparam int PER_W_DEFAULT = 4;
  localparam int MIN_MOD_VALUE = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_STOP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping.
// Produces a one-hot grant, the winner index and a valid flag.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Walk positions ptr, ptr+1, ... modulo NUM_REQ; the first hit wins.
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      pos = sum[IDX_W-1:0];
      if (!valid && req[pos]) begin
        valid      = 1'b1;
        idx        = pos;
        grant[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_counter_rr_scheduler.sv
// Round-robin scheduler sharing one external MOD counter between NUM_REQ timer clients.
// Sequences load/start/run/stop on the counter and returns a one-cycle done pulse per job.
module mod_counter_rr_scheduler
  import mod_counter_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int PER_W   = PER_W_DEFAULT
) (
  input  logic                     Clk_In,
  input  logic                     Reset_In,
  input  logic [NUM_REQ-1:0]       Req_In,
  input  logic [NUM_REQ*CNT_W-1:0] Req_MOD_Value_In,
  input  logic [NUM_REQ*CNT_W-1:0] Req_Preload_Value_In,
  input  logic [NUM_REQ*PER_W-1:0] Req_Periods_In,
  output logic [NUM_REQ-1:0]       Grant_Out,
  output logic [NUM_REQ-1:0]       Done_Out,
  output logic                     Error_Out,
  output logic                     Busy_Out,
  output logic                     Cnt_Enable_Out,
  output logic                     Cnt_Load_Out,
  output logic                     Cnt_Start_Out,
  output logic                     Cnt_Stop_Out,
  output logic [CNT_W-1:0]         Cnt_Preload_Value_Out,
  output logic [CNT_W-1:0]         Cnt_MOD_Value_Out,
  input  logic                     Cnt_Running_Flag_In,
  input  logic                     Cnt_Rollover_Flag_In
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [CNT_W-1:0] mod_arr [NUM_REQ];
  logic [CNT_W-1:0] pre_arr [NUM_REQ];
  logic [PER_W-1:0] per_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign mod_arr[gi] = Req_MOD_Value_In[gi*CNT_W +: CNT_W];
    assign pre_arr[gi] = Req_Preload_Value_In[gi*CNT_W +: CNT_W];
    assign per_arr[gi] = Req_Periods_In[gi*PER_W +: PER_W];
  end

  state_t             state_reg;
  logic [IDX_W-1:0]   ptr_reg, win_idx_reg;
  logic [NUM_REQ-1:0] grant_reg, done_reg;
  logic               error_reg, busy_reg, enable_reg;
  logic               load_reg, start_reg, stop_reg;
  logic [CNT_W-1:0]   preload_reg, mod_reg;
  logic [PER_W-1:0]   periods_reg, roll_cnt_reg, eff_periods;
  logic               err_flag_reg, hold_reg;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (Req_In),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign eff_periods = (periods_reg == '0) ? PER_W'(1) : periods_reg;

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      win_idx_reg  <= '0;
      grant_reg    <= '0;
      done_reg     <= '0;
      error_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      enable_reg   <= 1'b0;
      load_reg     <= 1'b0;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
      preload_reg  <= '0;
      mod_reg      <= '0;
      periods_reg  <= '0;
      roll_cnt_reg <= '0;
      err_flag_reg <= 1'b0;
      hold_reg     <= 1'b0;
    end else begin
      enable_reg <= 1'b1;
      unique case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_reg    <= pick_grant;
            win_idx_reg  <= pick_idx;
            mod_reg      <= mod_arr[pick_idx];
            preload_reg  <= pre_arr[pick_idx];
            periods_reg  <= per_arr[pick_idx];
            roll_cnt_reg <= '0;
            busy_reg     <= 1'b1;
            if (mod_arr[pick_idx] < CNT_W'(MIN_MOD_VALUE)) begin
              // Rejected job: one spare cycle so done lands where a stop slot would be.
              err_flag_reg <= 1'b1;
              hold_reg     <= 1'b1;
              state_reg    <= ST_DONE;
            end else begin
              err_flag_reg <= 1'b0;
              load_reg     <= 1'b1;
              state_reg    <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          load_reg <= 1'b0;
          if (Cnt_Running_Flag_In) begin
            stop_reg <= 1'b1;
          end else begin
            stop_reg  <= 1'b0;
            start_reg <= 1'b1;
            state_reg <= ST_START;
          end
        end
        ST_START: begin
          start_reg <= 1'b0;
          state_reg <= ST_RUN;
        end
        ST_RUN: begin
          if (Cnt_Rollover_Flag_In) begin
            roll_cnt_reg <= roll_cnt_reg + 1'b1;
            if ((roll_cnt_reg + 1'b1) >= eff_periods) begin
              stop_reg  <= 1'b1;
              state_reg <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          stop_reg  <= 1'b0;
          done_reg  <= grant_reg;
          error_reg <= err_flag_reg;
          state_reg <= ST_DONE;
        end
        ST_DONE: begin
          if (hold_reg) begin
            hold_reg <= 1'b0;
          end else if (done_reg == '0) begin
            done_reg  <= grant_reg;
            error_reg <= err_flag_reg;
          end else begin
            done_reg  <= '0;
            error_reg <= 1'b0;
            grant_reg <= '0;
            busy_reg  <= 1'b0;
            ptr_reg   <= (win_idx_reg == IDX_W'(NUM_REQ-1)) ? '0 : win_idx_reg + 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign Grant_Out             = grant_reg;
  assign Done_Out              = done_reg;
  assign Error_Out             = error_reg;
  assign Busy_Out              = busy_reg;
  assign Cnt_Enable_Out        = enable_reg;
  assign Cnt_Load_Out          = load_reg;
  assign Cnt_Start_Out         = start_reg;
  assign Cnt_Stop_Out          = stop_reg;
  assign Cnt_Preload_Value_Out = preload_reg;
  assign Cnt_MOD_Value_Out     = mod_reg;

endmodule
